mem_responder: RTL and testbench

Bus-side responder for the CPU memory interface. It accepts the CPU's address, write data and read/write strobes, and services each access from an internal byte RAM or a small I/O register page. A programmable number of wait states precedes each completion, and completion is signalled with a one-cycle RDY pulse. The block is the target end of the CPU's mADDR/mDIN/mDOUT/mOEN/mWE port and sits between the CPU and the board-level memory/IO.

---
 rtl/mem_responder_pkg.sv | 26 ++
 rtl/mem_responder_ram.sv | 24 ++
 rtl/mem_responder.sv | 158 +++++++++++++++
 tb/tb_mem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the CPU-side memory responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_responder_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Offsets inside the 16-byte IO page
  localparam logic [3:0] IO_OFS_OUT = 4'd0;
  localparam logic [3:0] IO_OFS_IN  = 4'd1;
  localparam logic [3:0] IO_OFS_CNT = 4'd2;

  // Value returned for reads of unassigned IO offsets
  localparam logic [7:0] IO_RD_DEFAULT = 8'h00;

  // True when the address falls in the IO page identified by its upper 12 bits
  function automatic logic in_io_page(input logic [15:0] addr, input logic [11:0] page);
    return (addr[15:4] == page);
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous byte RAM, no reset, contents undefined at power-up.
// Latency: read data registered, valid one cycle after the address is presented.
// Backpressure: none; a write or read is performed on every rising edge.
module mem_responder_ram #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 CLK,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           din,
  output logic [7:0]           dout
);

  logic [7:0] mem [2**ADDR_BITS];

  // Write when enabled; always register the read of the presented address
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Target end of the CPU memory port: services reads/writes from byte RAM or a 16-byte IO page.
// Latency: request sampled at edge N, RDY pulses (with read data on mDOUT) in cycle N+WAIT_STATES+1.
// Backpressure: none; new requests are only sampled in IDLE, strobes are ignored while an access is in flight.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          ADDR_BITS   = 12,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] IO_BASE     = 16'hFFF0
) (
  input  logic        CLK,
  input  logic        R,
  input  logic [15:0] mADDR,
  input  logic [7:0]  mDIN,
  input  logic        mOEN,
  input  logic        mWE,
  output logic [7:0]  mDOUT,
  output logic        RDY,
  input  logic [7:0]  IO_IN,
  output logic [7:0]  IO_OUT,
  output logic [7:0]  ACC_CNT
);

  // Wait counter load value; unused when there are no wait states
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic        latch;
  logic        done;

  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic        is_wr;

  logic        io_sel;
  logic [3:0]  io_ofs;
  logic [7:0]  io_rdata;
  logic [7:0]  rd_data;

  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [7:0]           ram_dout;

  // Next-state and strobe decode: IDLE -> (WAIT) -> DONE -> IDLE
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    latch    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (mWE | mOEN) begin
          latch = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nx = DONE;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and wait-counter registers
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Capture the request in IDLE; write wins when both strobes are high
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      addr_q <= 16'h0000;
      data_q <= 8'h00;
      is_wr  <= 1'b0;
    end else if (latch) begin
      addr_q <= mADDR;
      data_q <= mDIN;
      is_wr  <= mWE;
    end
  end

  assign io_sel = in_io_page(addr_q, IO_BASE[15:4]);
  assign io_ofs = addr_q[3:0];

  // In IDLE the RAM looks at the live bus address so the read is already under way
  // on the sampling edge; this keeps zero-wait-state reads correct.
  assign ram_addr = (state == IDLE) ? mADDR[ADDR_BITS-1:0] : addr_q[ADDR_BITS-1:0];
  // Gate with reset so an access aborted in DONE never lands in the RAM
  assign ram_we   = done & is_wr & ~io_sel & ~R;

  mem_responder_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .CLK  (CLK),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (data_q),
    .dout (ram_dout)
  );

  // IO page read mux; the count offset returns the value before this access's increment
  always_comb begin
    io_rdata = IO_RD_DEFAULT;
    case (io_ofs)
      IO_OFS_OUT: io_rdata = IO_OUT;
      IO_OFS_IN:  io_rdata = IO_IN;
      IO_OFS_CNT: io_rdata = ACC_CNT;
      default:    io_rdata = IO_RD_DEFAULT;
    endcase
  end

  assign rd_data = io_sel ? io_rdata : ram_dout;

  // Completion: pulse RDY, count the access, commit write or capture read data
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      mDOUT   <= 8'h00;
      RDY     <= 1'b0;
      IO_OUT  <= 8'h00;
      ACC_CNT <= 8'h00;
    end else begin
      RDY <= done;
      if (done) begin
        ACC_CNT <= ACC_CNT + 8'd1;
        if (is_wr) begin
          if (io_sel && (io_ofs == IO_OFS_OUT)) begin
            IO_OUT <= data_q;
          end
        end else begin
          mDOUT <= rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed steps plus random accesses against a reference model.
// Latency: checks RDY arrives WAIT_STATES+1 cycles after sampling, for one and zero wait states.
// Backpressure: n/a.
module tb_mem_responder;

  localparam int WS = 1;

  logic        CLK = 1'b0;
  logic        R;
  logic [15:0] mADDR;
  logic [7:0]  mDIN;
  logic        mOEN, mWE;
  logic [7:0]  IO_IN;
  logic [7:0]  mDOUT, IO_OUT, ACC_CNT;
  logic        RDY;

  logic        oen0, we0;
  logic [7:0]  mDOUT0, IO_OUT0, ACC_CNT0;
  logic        RDY0;

  always #5 CLK = ~CLK;

  mem_responder #(.ADDR_BITS(12), .WAIT_STATES(WS), .IO_BASE(16'hFFF0)) dut (
    .CLK(CLK), .R(R), .mADDR(mADDR), .mDIN(mDIN), .mOEN(mOEN), .mWE(mWE),
    .mDOUT(mDOUT), .RDY(RDY), .IO_IN(IO_IN), .IO_OUT(IO_OUT), .ACC_CNT(ACC_CNT)
  );

  mem_responder #(.ADDR_BITS(12), .WAIT_STATES(0), .IO_BASE(16'hFFF0)) dut0 (
    .CLK(CLK), .R(R), .mADDR(mADDR), .mDIN(mDIN), .mOEN(oen0), .mWE(we0),
    .mDOUT(mDOUT0), .RDY(RDY0), .IO_IN(IO_IN), .IO_OUT(IO_OUT0), .ACC_CNT(ACC_CNT0)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: what memory, IO register and bus outputs should hold
  logic [7:0] ram_m [4096];
  bit         ram_v [4096];
  logic [7:0] io_out_m, acc_m, dout_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_io(input logic [15:0] a);
    return a[15:4] == 12'hFFF;
  endfunction

  function automatic logic [7:0] ref_read(input logic [15:0] a, input logic [7:0] io_in);
    if (is_io(a)) begin
      case (a[3:0])
        4'd0:    return io_out_m;
        4'd1:    return io_in;
        4'd2:    return acc_m;
        default: return 8'h00;
      endcase
    end
    return ram_m[a[11:0]];
  endfunction

  task automatic ref_write(input logic [15:0] a, input logic [7:0] d);
    if (is_io(a)) begin
      if (a[3:0] == 4'd0) io_out_m = d;
    end else begin
      ram_m[a[11:0]] = d;
      ram_v[a[11:0]] = 1'b1;
    end
  endtask

  // One access on the WS=1 instance. hold keeps strobes up and scribbles mDIN until RDY.
  task automatic access(input logic we, input logic oe, input logic [15:0] a,
                        input logic [7:0] d, input bit hold, input string tag);
    int n;
    logic [7:0] exp_rd;
    exp_rd = ref_read(a, IO_IN);
    @(negedge CLK);
    mADDR = a; mDIN = d; mWE = we; mOEN = oe;
    @(posedge CLK);
    @(negedge CLK);
    if (hold) mDIN = 8'hFF;
    else begin mWE = 1'b0; mOEN = 1'b0; end
    n = 0;
    while (RDY !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    mWE = 1'b0; mOEN = 1'b0;
    chk({tag, " latency"}, 32'(n), 32'(WS + 1));
    if (we) ref_write(a, d);
    else    dout_m = exp_rd;
    acc_m = acc_m + 8'd1;
    chk({tag, " mDOUT"},   32'(mDOUT),   32'(dout_m));
    chk({tag, " ACC_CNT"}, 32'(ACC_CNT), 32'(acc_m));
    chk({tag, " IO_OUT"},  32'(IO_OUT),  32'(io_out_m));
    @(negedge CLK);
    chk({tag, " rdy one cycle"}, 32'(RDY), 32'd0);
  endtask

  task automatic model_reset();
    io_out_m = 8'h00; acc_m = 8'h00; dout_m = 8'h00;
  endtask

  initial begin
    int rdy_seen, n, pulses, last, first, cyc, bad_d, bad_gap;
    logic [15:0] ra;
    bit rw, ro;

    R = 1'b1; mADDR = 16'h0; mDIN = 8'h0; mOEN = 1'b0; mWE = 1'b0; IO_IN = 8'h0;
    oen0 = 1'b0; we0 = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("reset RDY",      32'(RDY),     32'd0);
    chk("reset mDOUT",    32'(mDOUT),   32'd0);
    chk("reset IO_OUT",   32'(IO_OUT),  32'd0);
    chk("reset ACC_CNT",  32'(ACC_CNT), 32'd0);
    chk("reset ACC_CNT0", 32'(ACC_CNT0), 32'd0);
    R = 1'b0;

    // Known content and non-zero outputs before the aborted access
    access(1'b1, 1'b0, 16'h0010, 8'hC3, 1'b0, "pre wr");
    access(1'b1, 1'b0, 16'hFFF0, 8'h55, 1'b0, "pre io");
    access(1'b0, 1'b1, 16'h0010, 8'h00, 1'b0, "pre rd");

    // Reset in the middle of a write
    @(negedge CLK);
    mADDR = 16'h0010; mDIN = 8'h5A; mWE = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    mWE = 1'b0; R = 1'b1;
    rdy_seen = 0;
    repeat (4) begin
      @(negedge CLK);
      if (RDY !== 1'b0) rdy_seen++;
    end
    chk("abort RDY",     32'(rdy_seen), 32'd0);
    chk("abort mDOUT",   32'(mDOUT),    32'd0);
    chk("abort IO_OUT",  32'(IO_OUT),   32'd0);
    chk("abort ACC_CNT", 32'(ACC_CNT),  32'd0);
    R = 1'b0;
    model_reset();
    access(1'b0, 1'b1, 16'h0010, 8'h00, 1'b0, "abort rd");
    chk("abort not written", 32'(mDOUT), 32'h0C3);

    // Clean reset, then RAM write/read
    @(negedge CLK); R = 1'b1;
    @(negedge CLK); R = 1'b0;
    model_reset();
    access(1'b1, 1'b0, 16'h0123, 8'hA5, 1'b0, "ram wr");
    access(1'b0, 1'b1, 16'h0123, 8'h00, 1'b0, "ram rd");
    chk("ram rd value", 32'(mDOUT),   32'h0A5);
    chk("ram acc two",  32'(ACC_CNT), 32'd2);

    // Mirroring above ADDR_BITS
    access(1'b1, 1'b0, 16'h1123, 8'h3C, 1'b0, "mirror wr");
    access(1'b0, 1'b1, 16'h0123, 8'h00, 1'b0, "mirror rd");
    chk("mirror value", 32'(mDOUT), 32'h03C);

    // IO page
    access(1'b1, 1'b0, 16'hFFF0, 8'h81, 1'b0, "io wr out");
    access(1'b0, 1'b1, 16'hFFF0, 8'h00, 1'b0, "io rd out");
    chk("io out value", 32'(mDOUT), 32'h081);
    IO_IN = 8'h7E;
    access(1'b0, 1'b1, 16'hFFF1, 8'h00, 1'b0, "io rd in");
    chk("io in value", 32'(mDOUT), 32'h07E);
    access(1'b0, 1'b1, 16'hFFF5, 8'h00, 1'b0, "io rd dflt");
    chk("io dflt value", 32'(mDOUT), 32'h000);

    // Both strobes, data disturbed during the wait
    access(1'b1, 1'b1, 16'h0200, 8'h11, 1'b1, "prio wr");
    chk("prio mDOUT kept", 32'(mDOUT), 32'h000);
    access(1'b0, 1'b1, 16'h0200, 8'h00, 1'b0, "prio rd");
    chk("prio value", 32'(mDOUT), 32'h011);

    // Random mix of reads and writes over RAM and IO page
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15))) : 16'($urandom);
      rw = 1'($urandom_range(0, 1));
      if (!rw && !is_io(ra) && !ram_v[ra[11:0]]) rw = 1'b1;
      ro = rw ? 1'($urandom_range(0, 1)) : 1'b1;
      IO_IN = 8'($urandom);
      access(rw, ro, ra, 8'($urandom), 1'b0, "rand");
    end

    // Zero wait states: 256 back-to-back count reads, then one more after the wrap
    @(negedge CLK); R = 1'b1;
    @(negedge CLK); R = 1'b0;
    model_reset();
    mADDR = 16'hFFF2; oen0 = 1'b1;
    pulses = 0; last = -1; first = -1; cyc = 0; bad_d = 0; bad_gap = 0;
    while (pulses < 256 && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
      if (RDY0 === 1'b1) begin
        if (mDOUT0 !== 8'(pulses)) bad_d++;
        if (last >= 0 && cyc - last != 2) bad_gap++;
        if (first < 0) first = cyc;
        last = cyc;
        pulses++;
      end
    end
    oen0 = 1'b0;
    chk("ws0 pulses",      32'(pulses),   32'd256);
    chk("ws0 first rdy",   32'(first),    32'd2);
    chk("ws0 gap errors",  32'(bad_gap),  32'd0);
    chk("ws0 data errors", 32'(bad_d),    32'd0);
    chk("ws0 acc wrap",    32'(ACC_CNT0), 32'd0);
    @(negedge CLK);
    oen0 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    oen0 = 1'b0;
    n = 0;
    while (RDY0 !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("ws0 latency",   32'(n),        32'd1);
    chk("ws0 cnt read",  32'(mDOUT0),   32'd0);
    chk("ws0 acc after", 32'(ACC_CNT0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
